// File: rtl/vec_irq_ctrl_pkg.sv
// vec_irq_pkg: shared types and constants for the vectored interrupt controller.
//   irq_state_t  - request FSM states
//   ISR_*        - reset-time contents of the ISR vector table
//   CH_*         - channel index of each interrupt source
//   default_vec  - reset vector for a channel index
//   idx_w        - width of a channel index for a given channel count
package vec_irq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_t;

    localparam logic [7:0] ISR_ZERO  = 8'h11;
    localparam logic [7:0] ISR_OVF   = 8'h33;
    localparam logic [7:0] ISR_ILLOP = 8'hF0;
    localparam logic [7:0] ISR_EXT   = 8'hAA;

    localparam int CH_ZERO  = 0;
    localparam int CH_OVF   = 1;
    localparam int CH_ILLOP = 2;
    localparam int CH_EXT   = 3;

    function automatic logic [7:0] default_vec(input int ch);
        case (ch)
            CH_ZERO:  return ISR_ZERO;
            CH_OVF:   return ISR_OVF;
            CH_ILLOP: return ISR_ILLOP;
            CH_EXT:   return ISR_EXT;
            default:  return 8'h00;
        endcase
    endfunction

    // A single-channel build still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_irq_ctrl_if.sv
// vec_irq_ctrl_if: request/acknowledge path between the interrupt controller
// and the control unit.
//   irq_req  - controller requests a PC load
//   irq_vec  - ISR address, frozen while irq_req is high
//   irq_id   - channel being requested
//   irq_ack  - control unit has taken irq_vec
//   eoi      - end of interrupt, retires the top in-service channel
// modport slave  : the interrupt controller
// modport master : the control unit
interface vec_irq_ctrl_if #(
    parameter int N_IRQ  = 4,
    parameter int ADDR_W = 8
);
    import vec_irq_pkg::*;

    localparam int ID_W = idx_w(N_IRQ);

    logic              irq_req;
    logic [ADDR_W-1:0] irq_vec;
    logic [ID_W-1:0]   irq_id;
    logic              irq_ack;
    logic              eoi;

    modport master (
        input  irq_req, irq_vec, irq_id,
        output irq_ack, eoi
    );

    modport slave (
        output irq_req, irq_vec, irq_id,
        input  irq_ack, eoi
    );

endinterface

// File: rtl/vec_irq_ctrl_prio_enc_n.sv
// prio_enc_n: highest-index-wins priority encoder.
//   req   - request vector
//   idx   - index of the highest set bit (0 when none set)
//   valid - at least one bit of req is set
module prio_enc_n #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_irq_ctrl.sv
// vec_irq_ctrl: clocked, maskable, vectored priority interrupt controller with
// sticky pending capture, writable vector table, req/ack handshake and nested
// in-service tracking.
//   clk        - system clock, rising edge
//   clr        - asynchronous active-low clear
//   irq_in     - raw sources (3 ext, 2 illegal op, 1 overflow, 0 zero)
//   mask_in    - per-channel request allow
//   edge_sel   - 1 = rising-edge capture, 0 = level capture
//   enable     - global request enable
//   vec_we     - vector table write strobe (vec_idx, vec_data)
//   cu         - handshake to the control unit (slave side)
//   pending    - sticky pending register
//   in_service - in-service register
//
// State table:
//   IDLE | no request outstanding; picks the best eligible channel
//   REQ  | irq_req high, irq_vec/irq_id frozen until ack or withdrawal
module vec_irq_ctrl
    import vec_irq_pkg::*;
#(
    parameter int N_IRQ  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [N_IRQ-1:0]         irq_in,
    input  logic [N_IRQ-1:0]         mask_in,
    input  logic [N_IRQ-1:0]         edge_sel,
    input  logic                     enable,
    input  logic                     vec_we,
    input  logic [idx_w(N_IRQ)-1:0]  vec_idx,
    input  logic [ADDR_W-1:0]        vec_data,
    vec_irq_ctrl_if.slave            cu,
    output logic [N_IRQ-1:0]         pending,
    output logic [N_IRQ-1:0]         in_service
);

    localparam int ID_W = idx_w(N_IRQ);

    irq_state_t        state;
    logic              req_q;
    logic [ADDR_W-1:0] vec_q;
    logic [ID_W-1:0]   id_q;

    logic [N_IRQ-1:0]  irq_prev;
    logic [N_IRQ-1:0]  set_vec;
    logic [N_IRQ-1:0]  ack_vec;
    logic [N_IRQ-1:0]  eoi_vec;
    logic [N_IRQ-1:0]  above;
    logic [N_IRQ-1:0]  elig;
    logic [ADDR_W-1:0] vec_tbl [N_IRQ];

    logic [ID_W-1:0]   sel_idx;
    logic              sel_valid;
    logic [ID_W-1:0]   top_idx;
    logic              top_valid;
    logic              ack_take;
    logic              withdraw;

    prio_enc_n #(.N(N_IRQ), .W(ID_W)) u_top_enc (
        .req   (in_service),
        .idx   (top_idx),
        .valid (top_valid)
    );

    // Only channels strictly above the current in-service level may nest.
    always_comb begin
        above = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            above[i] = ~top_valid | (i > int'(top_idx));
        end
    end

    assign elig = pending & mask_in & above;

    prio_enc_n #(.N(N_IRQ), .W(ID_W)) u_sel_enc (
        .req   (elig),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    assign set_vec  = irq_in & (~edge_sel | ~irq_prev);
    assign ack_take = (state == REQ) & cu.irq_ack;
    assign ack_vec  = ack_take ? (N_IRQ'(1) << id_q) : '0;
    assign eoi_vec  = (cu.eoi & top_valid) ? (N_IRQ'(1) << top_idx) : '0;
    assign withdraw = ~enable | ~mask_in[id_q];

    // A new capture in the ack cycle wins over the ack clear; eoi retires the
    // old top bit before the ack sets the new one.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            irq_prev   <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            irq_prev   <= irq_in;
            pending    <= (pending & ~ack_vec) | set_vec;
            in_service <= (in_service & ~eoi_vec) | ack_vec;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < N_IRQ; i++) begin
                vec_tbl[i] <= ADDR_W'(default_vec(i));
            end
        end else if (vec_we && ({1'b0, vec_idx} < (ID_W+1)'(N_IRQ))) begin
            vec_tbl[vec_idx] <= vec_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            req_q <= 1'b0;
            vec_q <= '0;
            id_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && sel_valid) begin
                        state <= REQ;
                        req_q <= 1'b1;
                        id_q  <= sel_idx;
                        vec_q <= vec_tbl[sel_idx];
                    end
                end
                REQ: begin
                    if (cu.irq_ack || withdraw) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign cu.irq_req = req_q;
    assign cu.irq_vec = vec_q;
    assign cu.irq_id  = id_q;

endmodule

// File: tb/tb_vec_irq_ctrl.sv
module tb_vec_irq_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] irq_in, mask_in, edge_sel;
    logic       enable, vec_we;
    logic [1:0] vec_idx;
    logic [7:0] vec_data;
    logic [3:0] pending, in_service;

    int checks   = 0;
    int failures = 0;

    vec_irq_ctrl_if #(.N_IRQ(4), .ADDR_W(8)) cu();

    vec_irq_ctrl #(.N_IRQ(4), .ADDR_W(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .irq_in     (irq_in),
        .mask_in    (mask_in),
        .edge_sel   (edge_sel),
        .enable     (enable),
        .vec_we     (vec_we),
        .vec_idx    (vec_idx),
        .vec_data   (vec_data),
        .cu         (cu),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    bit         m_pend [4];
    bit         m_ins  [4];
    bit         m_prev [4];
    bit         m_req;
    int         m_id;
    logic [7:0] m_vec;
    logic [7:0] m_tbl  [4];

    function automatic logic [3:0] pack4(input bit a [4]);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = a[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0; m_ins[i] = 0; m_prev[i] = 0;
        end
        m_req = 0; m_id = 0; m_vec = 8'h00;
        m_tbl[0] = 8'h11; m_tbl[1] = 8'h33; m_tbl[2] = 8'hF0; m_tbl[3] = 8'hAA;
    endtask

    task automatic model_step();
        int  top, sel;
        bit  take;
        bit  n_pend [4];
        bit  n_ins  [4];
        top = -1;
        for (int i = 0; i < 4; i++) if (m_ins[i]) top = i;
        sel = -1;
        for (int i = 0; i < 4; i++) if (m_pend[i] && mask_in[i] && i > top) sel = i;
        take = m_req && cu.irq_ack;
        for (int i = 0; i < 4; i++) begin
            n_pend[i] = m_pend[i];
            if (take && i == m_id) n_pend[i] = 0;
            if (edge_sel[i] ? (irq_in[i] && !m_prev[i]) : irq_in[i]) n_pend[i] = 1;
            n_ins[i] = m_ins[i];
        end
        if (cu.eoi && top >= 0) n_ins[top] = 0;
        if (take) n_ins[m_id] = 1;
        if (!m_req) begin
            if (enable && sel >= 0) begin
                m_req = 1; m_id = sel; m_vec = m_tbl[sel];
            end
        end else if (take || !enable || !mask_in[m_id]) begin
            m_req = 0;
        end
        if (vec_we) m_tbl[vec_idx] = vec_data;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = n_pend[i]; m_ins[i] = n_ins[i]; m_prev[i] = irq_in[i];
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] mid;
        @(posedge clk);
        model_step();
        #1;
        mid = m_id;
        chk("model_req",  {31'd0, cu.irq_req}, {31'd0, m_req});
        chk("model_vec",  {24'd0, cu.irq_vec}, {24'd0, m_vec});
        chk("model_id",   {30'd0, cu.irq_id},  {30'd0, mid[1:0]});
        chk("model_pend", {28'd0, pending},    {28'd0, pack4(m_pend)});
        chk("model_ins",  {28'd0, in_service}, {28'd0, pack4(m_ins)});
        cu.irq_ack = 1'b0;
        cu.eoi     = 1'b0;
        vec_we     = 1'b0;
    endtask

    task automatic wait_req(input int lim);
        int n;
        n = 0;
        while (!cu.irq_req && n < lim) begin
            tick();
            n++;
        end
        chk("wait_req", {31'd0, cu.irq_req}, 32'd1);
    endtask

    task automatic drain();
        irq_in = 4'b0000;
        for (int n = 0; n < 12; n++) begin
            if (cu.irq_req) cu.irq_ack = 1'b1;
            else if (|in_service) cu.eoi = 1'b1;
            tick();
        end
        chk("drain", {28'd0, pending | in_service}, 32'd0);
    endtask

    // Asynchronous clear asserted away from the clock edge.
    task automatic async_reset();
        #2 clr = 1'b0;
        #1;
        model_reset();
        chk("rst_req",  {31'd0, cu.irq_req}, 32'd0);
        chk("rst_vec",  {24'd0, cu.irq_vec}, 32'd0);
        chk("rst_id",   {30'd0, cu.irq_id},  32'd0);
        chk("rst_pend", {28'd0, pending},    32'd0);
        chk("rst_ins",  {28'd0, in_service}, 32'd0);
        #1 clr = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] irq;
        bit         ack;
        bit         eoi;
        bit         x_req;
        logic [7:0] x_vec;
        logic [1:0] x_id;
        logic [3:0] x_pend;
        logic [3:0] x_ins;
    } row_t;

    row_t tbl [13];

    function automatic row_t mk(input logic [3:0] irq, input bit ack, input bit eoi,
                                input bit x_req, input logic [7:0] x_vec,
                                input logic [1:0] x_id, input logic [3:0] x_pend,
                                input logic [3:0] x_ins);
        row_t r;
        r.irq = irq; r.ack = ack; r.eoi = eoi; r.x_req = x_req; r.x_vec = x_vec;
        r.x_id = x_id; r.x_pend = x_pend; r.x_ins = x_ins;
        return r;
    endfunction

    initial begin
        int cnt;
        tbl[0]  = mk(4'b1000, 0, 0, 0, 8'h00, 2'd0, 4'b1000, 4'b0000);
        tbl[1]  = mk(4'b1000, 0, 0, 1, 8'hAA, 2'd3, 4'b1000, 4'b0000);
        tbl[2]  = mk(4'b0000, 1, 0, 0, 8'hAA, 2'd3, 4'b0000, 4'b1000);
        tbl[3]  = mk(4'b0000, 0, 1, 0, 8'hAA, 2'd3, 4'b0000, 4'b0000);
        tbl[4]  = mk(4'b0011, 0, 0, 0, 8'hAA, 2'd3, 4'b0011, 4'b0000);
        tbl[5]  = mk(4'b0000, 0, 0, 1, 8'h33, 2'd1, 4'b0011, 4'b0000);
        tbl[6]  = mk(4'b0000, 1, 0, 0, 8'h33, 2'd1, 4'b0001, 4'b0010);
        tbl[7]  = mk(4'b0000, 0, 0, 0, 8'h33, 2'd1, 4'b0001, 4'b0010);
        tbl[8]  = mk(4'b0000, 0, 0, 0, 8'h33, 2'd1, 4'b0001, 4'b0010);
        tbl[9]  = mk(4'b0000, 0, 1, 0, 8'h33, 2'd1, 4'b0001, 4'b0000);
        tbl[10] = mk(4'b0000, 0, 0, 1, 8'h11, 2'd0, 4'b0001, 4'b0000);
        tbl[11] = mk(4'b0000, 1, 0, 0, 8'h11, 2'd0, 4'b0000, 4'b0001);
        tbl[12] = mk(4'b0000, 0, 1, 0, 8'h11, 2'd0, 4'b0000, 4'b0000);

        clr = 1'b0;
        irq_in = 4'h0; mask_in = 4'hF; edge_sel = 4'h0; enable = 1'b1;
        vec_we = 1'b0; vec_idx = 2'd0; vec_data = 8'h00;
        cu.irq_ack = 1'b0; cu.eoi = 1'b0;
        model_reset();
        #7 clr = 1'b1;
        chk("rst_req",  {31'd0, cu.irq_req}, 32'd0);
        chk("rst_pend", {28'd0, pending},    32'd0);
        chk("rst_ins",  {28'd0, in_service}, 32'd0);

        // Reset defaults and priority/blocking sequence
        for (int k = 0; k < 13; k++) begin
            irq_in = tbl[k].irq; cu.irq_ack = tbl[k].ack; cu.eoi = tbl[k].eoi;
            tick();
            chk($sformatf("tbl%0d_req", k),  {31'd0, cu.irq_req}, {31'd0, tbl[k].x_req});
            chk($sformatf("tbl%0d_vec", k),  {24'd0, cu.irq_vec}, {24'd0, tbl[k].x_vec});
            chk($sformatf("tbl%0d_id", k),   {30'd0, cu.irq_id},  {30'd0, tbl[k].x_id});
            chk($sformatf("tbl%0d_pend", k), {28'd0, pending},    {28'd0, tbl[k].x_pend});
            chk($sformatf("tbl%0d_ins", k),  {28'd0, in_service}, {28'd0, tbl[k].x_ins});
        end

        // Reset mid-handshake drops the request immediately
        irq_in = 4'b1000;
        tick(); tick();
        chk("mid_req_up", {31'd0, cu.irq_req}, 32'd1);
        irq_in = 4'b0000;
        async_reset();

        // Nesting
        edge_sel = 4'hF;
        irq_in = 4'b0010; tick();
        irq_in = 4'b0000; wait_req(5);
        chk("nest_vec_ovf", {24'd0, cu.irq_vec}, 32'h33);
        cu.irq_ack = 1'b1; tick();
        chk("nest_ins1", {28'd0, in_service}, 32'b0010);
        irq_in = 4'b1000; tick();
        irq_in = 4'b0000; wait_req(5);
        chk("nest_vec_ext", {24'd0, cu.irq_vec}, 32'hAA);
        cu.irq_ack = 1'b1; tick();
        chk("nest_ins2", {28'd0, in_service}, 32'b1010);
        cu.eoi = 1'b1; tick();
        chk("nest_eoi1", {28'd0, in_service}, 32'b0010);
        cu.eoi = 1'b1; tick();
        chk("nest_eoi2", {28'd0, in_service}, 32'b0000);

        // Edge versus level
        edge_sel = 4'b0001; irq_in = 4'b0001; cnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (cu.irq_req) begin cu.irq_ack = 1'b1; cnt++; end
            else if (in_service[0]) cu.eoi = 1'b1;
            tick();
        end
        chk("edge_once", cnt, 32'd1);
        edge_sel = 4'b0000; cnt = 0;
        for (int n = 0; n < 12; n++) begin
            if (cu.irq_req) begin cu.irq_ack = 1'b1; cnt++; end
            else if (in_service[0]) cu.eoi = 1'b1;
            tick();
        end
        chk("level_rereq", {31'd0, cnt >= 2}, 32'd1);
        drain();

        // Vector write and withdrawal
        vec_we = 1'b1; vec_idx = 2'd2; vec_data = 8'h5C; tick();
        irq_in = 4'b0100; tick();
        wait_req(5);
        chk("wr_vec", {24'd0, cu.irq_vec}, 32'h5C);
        vec_we = 1'b1; vec_idx = 2'd2; vec_data = 8'h77; tick();
        chk("wr_frozen", {24'd0, cu.irq_vec}, 32'h5C);
        mask_in = 4'b1011; tick();
        chk("wd_req", {31'd0, cu.irq_req}, 32'd0);
        chk("wd_pend2", {31'd0, pending[2]}, 32'd1);
        irq_in = 4'b0000; tick();
        mask_in = 4'hF; wait_req(5);
        chk("wr_new_vec", {24'd0, cu.irq_vec}, 32'h77);
        drain();

        // Simultaneous events
        edge_sel = 4'b1000;
        irq_in = 4'b0010; wait_req(5);
        chk("sim_id1", {30'd0, cu.irq_id}, 32'd1);
        cu.irq_ack = 1'b1; irq_in = 4'b0000; tick();
        chk("sim_ins1", {28'd0, in_service}, 32'b0010);
        irq_in = 4'b1000; tick();
        wait_req(5);
        chk("sim_id3", {30'd0, cu.irq_id}, 32'd3);
        irq_in = 4'b0000; tick();
        irq_in = 4'b1000; cu.irq_ack = 1'b1; cu.eoi = 1'b1; tick();
        chk("sim_ins_swap", {28'd0, in_service}, 32'b1000);
        chk("sim_pend_kept", {31'd0, pending[3]}, 32'd1);
        cu.irq_ack = 1'b1; tick();
        chk("stray_ack_req",  {31'd0, cu.irq_req}, 32'd0);
        chk("stray_ack_ins",  {28'd0, in_service}, 32'b1000);
        chk("stray_ack_pend", {28'd0, pending},    32'b1000);
        drain();

        // Randomised run against the model
        edge_sel = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
            mask_in  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 31) == 0) edge_sel = 4'($urandom);
            enable   = ($urandom_range(0, 15) != 0);
            cu.irq_ack = 1'($urandom_range(0, 1));
            cu.eoi     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) begin
                vec_we = 1'b1; vec_idx = 2'($urandom); vec_data = 8'($urandom);
            end
            tick();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
